// File: rtl/alu_req_issuer.sv
// Command issuer for a combinational ALU: registers one command at a time into the ALU and
// queues its results in a DEPTH-entry response FIFO. Define ALU_REQ_ISSUER_ERR_EN to trap op codes 9-15.
module alu_req_issuer #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   // Command channel
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_op,
   input  logic [N-1:0] req_a,
   input  logic [N-1:0] req_b,
   // Registered ALU drive
   output logic [3:0]   alu_select,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   // ALU outputs
   input  logic [N-1:0] alu_result,
   input  logic         alu_neg,
   input  logic         alu_zero,
   input  logic         alu_carry,
   input  logic         alu_overflow,
   input  logic         alu_nop,
   // Response channel
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_result,
   output logic [4:0]   rsp_flags,
   output logic         rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
`ifdef ALU_REQ_ISSUER_ERR_EN
   localparam int unsigned EW = N + 6;
`else
   localparam int unsigned EW = N + 5;
`endif
   localparam logic [3:0]  OpNop    = 4'd8;
   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
   localparam logic [AW:0] CntOne   = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne = AW'(1);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e          state_q, state_d;
   logic            accept, push, pop;
   logic [3:0]      sel_d;
   logic [4:0]      alu_flags;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   rd_entry;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
`ifdef ALU_REQ_ISSUER_ERR_EN
   logic            err_d, err_q;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StIssue;
         StIssue: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      push      = 1'b0;
      unique case (state_q)
         StIdle:  req_ready = (count_q < DepthCnt);
         StIssue: push      = 1'b1;
         default: begin
            req_ready = 1'b0;
            push      = 1'b0;
         end
      endcase
   end

   assign accept = req_valid && req_ready;

   // ---------------------------------------------------------------- ALU drive
   always_comb begin
      sel_d = req_op;
`ifdef ALU_REQ_ISSUER_ERR_EN
      err_d = (req_op > OpNop);
      // Invalid ops park the ALU on NOP; the response is synthesised locally.
      if (err_d) sel_d = OpNop;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_select <= OpNop;
         alu_a      <= '0;
         alu_b      <= '0;
`ifdef ALU_REQ_ISSUER_ERR_EN
         err_q      <= 1'b0;
`endif
      end else if (accept) begin
         alu_select <= sel_d;
         alu_a      <= req_a;
         alu_b      <= req_b;
`ifdef ALU_REQ_ISSUER_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   assign alu_flags = {alu_nop, alu_overflow, alu_carry, alu_zero, alu_neg};

`ifdef ALU_REQ_ISSUER_ERR_EN
   assign push_data = err_q ? {{N{1'b0}}, 5'b00000, 1'b1} : {alu_result, alu_flags, 1'b0};
`else
   assign push_data = {alu_result, alu_flags};
`endif

   // ---------------------------------------------------------------- Response FIFO
   assign pop = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
         count_q <= count_d;
      end
   end

   assign rd_entry   = mem_q[rd_ptr_q];
   assign rsp_valid  = (count_q != '0);
   assign rsp_result = rd_entry[EW-1 -: N];
   assign rsp_flags  = rd_entry[EW-N-1 -: 5];
`ifdef ALU_REQ_ISSUER_ERR_EN
   // Gated so an empty FIFO never exposes uninitialised storage on the error bit.
   assign rsp_err    = rsp_valid & rd_entry[0];
`else
   assign rsp_err    = 1'b0;
`endif

endmodule
